// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: drives one single-bit ALU slice over WIDTH cycles,
// LSB first, and assembles the registered result plus NZCV flags.
module bit_serial_alu_ctrl #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             cout_q, cout_d;

    logic             b_in_c, sum_c, cout_c, slice_c, arith_c;

    // Single-bit ALU slice; subtraction is A + ~B + 1 with the +1 preloaded into the carry flop.
    always_comb begin
        arith_c = (op_q == OP_ADD) || (op_q == OP_SUB);
        b_in_c  = b_sh_q[0] ^ (op_q == OP_SUB);
        sum_c   = a_sh_q[0] ^ b_in_c ^ cy_q;
        cout_c  = (a_sh_q[0] & b_in_c) | (a_sh_q[0] & cy_q) | (b_in_c & cy_q);
        case (op_q)
            OP_PASS:        slice_c = b_sh_q[0];
            OP_ADD, OP_SUB: slice_c = sum_c;
            OP_AND:         slice_c = a_sh_q[0] & b_sh_q[0];
            OP_OR:          slice_c = a_sh_q[0] | b_sh_q[0];
            OP_XOR:         slice_c = a_sh_q[0] ^ b_sh_q[0];
            default:        slice_c = 1'b0;
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        cy_d     = cy_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        neg_d    = neg_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        cout_d   = cout_q;

        case (state_q)
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {slice_c, res_sh_q[WIDTH-1:1]};
                cy_d     = cout_c;
                if (cnt_q == LAST_BIT) begin
                    // cy_q here is the carry into the MSB, so overflow is cin(msb) ^ cout(msb).
                    result_d = res_sh_d;
                    neg_d    = slice_c;
                    zero_d   = ~|res_sh_d;
                    cout_d   = arith_c & cout_c;
                    ovf_d    = arith_c & (cy_q ^ cout_c);
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    op_d    = sel;
                    cnt_d   = '0;
                    cy_d    = (sel == OP_SUB);
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            cy_q     <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            cy_q     <= cy_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            cout_q   <= cout_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign negative  = neg_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed testbench for bit_serial_alu_ctrl (WIDTH=64): arithmetic, logic,
// flags, handshake timing, ignored/back-to-back starts and async reset.
module tb_bit_serial_alu_ctrl;

    localparam int unsigned WIDTH = 64;
    localparam int MAX_WAIT = 200;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       sel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;

    int total = 0;
    int bad   = 0;

    bit_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept one op at edge 0, then wait (bounded) for done; edges counts edges after edge 0.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [2:0] sv, output int edges, output bit busy_ok);
        @(negedge clk);
        a = av; b = bv; sel = sv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        busy_ok = busy;
        while (!done && edges < MAX_WAIT) begin
            @(posedge clk); #1;
            edges++;
            if (!done && !busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; a = '0; b = '0; sel = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
        total++; if ({negative, zero, carry_out, overflow} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {negative, zero, carry_out, overflow}); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_add();
        int e; bit bok;
        run_op(64'd5, 64'd3, 3'b010, e, bok);
        // done is visible after edge WIDTH, i.e. sampled high at the (WIDTH+1)th edge
        total++; if (e !== WIDTH) begin bad++; $display("FAIL add_latency got=%0d exp=%0d", e, WIDTH); end
        total++; if (bok !== 1'b1) begin bad++; $display("FAIL add_busy got=%b exp=1", bok); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL add_busy_at_done got=%b exp=0", busy); end
        total++; if (result !== 64'd8) begin bad++; $display("FAIL add_result got=%h exp=8", result); end
        total++; if ({negative, zero, carry_out, overflow} !== 4'b0000) begin
            bad++; $display("FAIL add_flags got=%b exp=0000", {negative, zero, carry_out, overflow}); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL add_done_pulse got=%b exp=0", done); end
        total++; if (result !== 64'd8) begin bad++; $display("FAIL add_hold got=%h exp=8", result); end
    endtask

    // Arithmetic vectors: {negative, zero, carry_out, overflow}.
    task automatic test_arith();
        logic [WIDTH-1:0] va [6];
        logic [WIDTH-1:0] vb [6];
        logic [2:0]       vs [6];
        logic [WIDTH-1:0] vr [6];
        logic [3:0]       vf [6];
        int e; bit bok;
        va[0] = 64'd3;                  vb[0] = 64'd5; vs[0] = 3'b011; vr[0] = 64'hFFFF_FFFF_FFFF_FFFE; vf[0] = 4'b1000;
        va[1] = 64'd5;                  vb[1] = 64'd3; vs[1] = 3'b011; vr[1] = 64'd2;                   vf[1] = 4'b0010;
        va[2] = 64'h7FFF_FFFF_FFFF_FFFF; vb[2] = 64'd1; vs[2] = 3'b010; vr[2] = 64'h8000_0000_0000_0000; vf[2] = 4'b1001;
        va[3] = 64'hFFFF_FFFF_FFFF_FFFF; vb[3] = 64'd1; vs[3] = 3'b010; vr[3] = 64'd0;                   vf[3] = 4'b0110;
        va[4] = 64'h8000_0000_0000_0000; vb[4] = 64'd1; vs[4] = 3'b011; vr[4] = 64'h7FFF_FFFF_FFFF_FFFF; vf[4] = 4'b0011;
        va[5] = 64'd7;                  vb[5] = 64'd7; vs[5] = 3'b011; vr[5] = 64'd0;                   vf[5] = 4'b0110;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vs[i], e, bok);
            total++; if (e !== WIDTH) begin bad++; $display("FAIL arith%0d_latency got=%0d exp=%0d", i, e, WIDTH); end
            total++; if (result !== vr[i]) begin bad++; $display("FAIL arith%0d_result got=%h exp=%h", i, result, vr[i]); end
            total++; if ({negative, zero, carry_out, overflow} !== vf[i]) begin
                bad++; $display("FAIL arith%0d_flags got=%b exp=%b", i, {negative, zero, carry_out, overflow}, vf[i]); end
        end
    endtask

    task automatic test_logic();
        logic [WIDTH-1:0] va [6];
        logic [WIDTH-1:0] vb [6];
        logic [2:0]       vs [6];
        logic [WIDTH-1:0] vr [6];
        logic [3:0]       vf [6];
        int e; bit bok;
        va[0] = 64'hF0F0; vb[0] = 64'hFF00; vs[0] = 3'b100; vr[0] = 64'hF000; vf[0] = 4'b0000;
        va[1] = 64'hF0F0; vb[1] = 64'hFF00; vs[1] = 3'b101; vr[1] = 64'hFFF0; vf[1] = 4'b0000;
        va[2] = 64'hF0F0; vb[2] = 64'hFF00; vs[2] = 3'b110; vr[2] = 64'h0FF0; vf[2] = 4'b0000;
        va[3] = 64'hF0F0; vb[3] = 64'hFF00; vs[3] = 3'b000; vr[3] = 64'hFF00; vf[3] = 4'b0000;
        va[4] = 64'h1234; vb[4] = 64'h1234; vs[4] = 3'b110; vr[4] = 64'd0;    vf[4] = 4'b0100;
        va[5] = 64'hFFFF_FFFF_FFFF_FFFF; vb[5] = 64'hFFFF_FFFF_FFFF_FFFF; vs[5] = 3'b111; vr[5] = 64'd0; vf[5] = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vs[i], e, bok);
            total++; if (e !== WIDTH) begin bad++; $display("FAIL logic%0d_latency got=%0d exp=%0d", i, e, WIDTH); end
            total++; if (result !== vr[i]) begin bad++; $display("FAIL logic%0d_result got=%h exp=%h", i, result, vr[i]); end
            total++; if ({negative, zero, carry_out, overflow} !== vf[i]) begin
                bad++; $display("FAIL logic%0d_flags got=%b exp=%b", i, {negative, zero, carry_out, overflow}, vf[i]); end
        end
        run_op(64'd5, 64'd3, 3'b001, e, bok);
        total++; if (e !== WIDTH) begin bad++; $display("FAIL reserved_latency got=%0d exp=%0d", e, WIDTH); end
        total++; if ({result, negative, zero, carry_out, overflow} !== {64'd0, 4'b0100}) begin
            bad++; $display("FAIL reserved_out got=%h/%b exp=0/0100", result, {negative, zero, carry_out, overflow}); end
    endtask

    task automatic test_ignore_start();
        int e;
        @(negedge clk);
        a = 64'd5; b = 64'd3; sel = 3'b010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        a = 64'd100; b = 64'd200; sel = 3'b110; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e = 11;
        while (!done && e < MAX_WAIT) begin
            @(posedge clk); #1;
            e++;
        end
        total++; if (e !== WIDTH) begin bad++; $display("FAIL ignore_latency got=%0d exp=%0d", e, WIDTH); end
        total++; if (result !== 64'd8) begin bad++; $display("FAIL ignore_result got=%h exp=8", result); end
        @(posedge clk); #1;
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL ignore_no_queue got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_back_to_back();
        int e; bit bok;
        run_op(64'd1, 64'd2, 3'b010, e, bok);
        total++; if (result !== 64'd3) begin bad++; $display("FAIL b2b_first got=%h exp=3", result); end
        a = 64'd10; b = 64'd4; sel = 3'b011; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL b2b_accept got=%b exp=10", {busy, done}); end
        e = 0;
        while (!done && e < MAX_WAIT) begin
            @(posedge clk); #1;
            e++;
            if (e == 30 && result !== 64'd3) begin
                total++; bad++; $display("FAIL b2b_hold_during_run got=%h exp=3", result);
            end
        end
        total++; if (e !== WIDTH) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", e, WIDTH); end
        total++; if (result !== 64'd6) begin bad++; $display("FAIL b2b_result got=%h exp=6", result); end
        total++; if ({negative, zero, carry_out, overflow} !== 4'b0010) begin
            bad++; $display("FAIL b2b_flags got=%b exp=0010", {negative, zero, carry_out, overflow}); end
    endtask

    task automatic test_reset_mid();
        int e; bit bok;
        @(negedge clk);
        a = 64'd5; b = 64'd3; sel = 3'b010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL midrst_ctrl got=%b exp=00", {busy, done}); end
        total++; if (result !== '0) begin bad++; $display("FAIL midrst_result got=%h exp=0", result); end
        total++; if ({negative, zero, carry_out, overflow} !== 4'b0000) begin
            bad++; $display("FAIL midrst_flags got=%b exp=0000", {negative, zero, carry_out, overflow}); end
        @(negedge clk);
        reset_n = 1'b1;
        run_op(64'd1, 64'd1, 3'b010, e, bok);
        total++; if (e !== WIDTH) begin bad++; $display("FAIL midrst_latency got=%0d exp=%0d", e, WIDTH); end
        total++; if (result !== 64'd2) begin bad++; $display("FAIL midrst_result2 got=%h exp=2", result); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_arith();
        test_logic();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
